// File: rtl/ddr3_slot_bridge_if.sv
// Slot DDR3 byte port and DDRAM Avalon-MM port bundled for the slot bridge.
// The bridge uses the slave view; slot logic and memory model use the master view.
interface ddr3_slot_bridge_if;
   logic        ddr3_request;
   logic [27:0] ddr3_addr;
   logic        ddr3_rd;
   logic        ddr3_wr;
   logic [7:0]  ddr3_din;
   logic [7:0]  ddr3_dout;
   logic        ddr3_ready;

   logic        ddram_busy;
   logic [7:0]  ddram_burstcnt;
   logic [28:0] ddram_addr;
   logic        ddram_rd;
   logic        ddram_we;
   logic [63:0] ddram_din;
   logic [7:0]  ddram_be;
   logic [63:0] ddram_dout;
   logic        ddram_dout_ready;

   modport slave (
      input  ddr3_request, ddr3_addr, ddr3_rd, ddr3_wr, ddr3_din,
      output ddr3_dout, ddr3_ready,
      input  ddram_busy, ddram_dout, ddram_dout_ready,
      output ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be
   );

   modport master (
      output ddr3_request, ddr3_addr, ddr3_rd, ddr3_wr, ddr3_din,
      input  ddr3_dout, ddr3_ready,
      output ddram_busy, ddram_dout, ddram_dout_ready,
      input  ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be
   );
endinterface

// File: rtl/ddr3_slot_bridge.sv
// Byte-wide slot DDR3 port to single-beat 64-bit DDRAM bridge with a one-line
// write-through read cache so sequential byte reads cost one DDRAM access per word.
module ddr3_slot_bridge #(
   parameter logic [28:0] BASE_ADDR = 29'h0600_0000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ddr3_slot_bridge_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_CMD  = 2'd1,
      S_RD_WAIT = 2'd2,
      S_WR_CMD  = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_ready;
   logic [7:0]  r_dout;
   logic        r_ddram_rd;
   logic        r_ddram_we;
   logic [7:0]  r_ddram_be;
   logic [63:0] r_ddram_din;
   logic [28:0] r_ddram_addr;
   logic [24:0] r_line_tag;
   logic [63:0] r_line_data;
   logic        r_line_valid;
   logic [24:0] r_pend_tag;
   logic [2:0]  r_pend_lane;

   state_t      w_nxt_state;
   logic        w_nxt_ready;
   logic [7:0]  w_nxt_dout;
   logic        w_nxt_ddram_rd;
   logic        w_nxt_ddram_we;
   logic [7:0]  w_nxt_ddram_be;
   logic [63:0] w_nxt_ddram_din;
   logic [28:0] w_nxt_ddram_addr;
   logic [24:0] w_nxt_line_tag;
   logic [63:0] w_nxt_line_data;
   logic        w_nxt_line_valid;
   logic [24:0] w_nxt_pend_tag;
   logic [2:0]  w_nxt_pend_lane;

   logic [24:0] w_tag;
   logic [2:0]  w_lane;
   logic [28:0] w_word_addr;
   logic        w_hit;

   assign w_tag       = bus.ddr3_addr[27:3];
   assign w_lane      = bus.ddr3_addr[2:0];
   // 29-bit sum: carries out of bit 28 are dropped on purpose
   assign w_word_addr = BASE_ADDR + {4'd0, w_tag};
   assign w_hit       = r_line_valid && (r_line_tag == w_tag);

   // Next-state and next-output logic for the bridge FSM and cache line
   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_ready      = r_ready;
      w_nxt_dout       = r_dout;
      w_nxt_ddram_rd   = r_ddram_rd;
      w_nxt_ddram_we   = r_ddram_we;
      w_nxt_ddram_be   = r_ddram_be;
      w_nxt_ddram_din  = r_ddram_din;
      w_nxt_ddram_addr = r_ddram_addr;
      w_nxt_line_tag   = r_line_tag;
      w_nxt_line_data  = r_line_data;
      w_nxt_line_valid = r_line_valid;
      w_nxt_pend_tag   = r_pend_tag;
      w_nxt_pend_lane  = r_pend_lane;

      case (r_state)
         S_IDLE: begin
            // Write has priority over a simultaneous read strobe
            if (bus.ddr3_request && bus.ddr3_wr) begin
               w_nxt_state      = S_WR_CMD;
               w_nxt_ready      = 1'b0;
               w_nxt_ddram_we   = 1'b1;
               w_nxt_ddram_be   = 8'b0000_0001 << w_lane;
               w_nxt_ddram_din  = {8{bus.ddr3_din}};
               w_nxt_ddram_addr = w_word_addr;
               if (w_hit) begin
                  w_nxt_line_data[{w_lane, 3'b000} +: 8] = bus.ddr3_din;
               end else begin
                  w_nxt_line_data = r_line_data;
               end
            end else if (bus.ddr3_request && bus.ddr3_rd) begin
               if (w_hit) begin
                  w_nxt_dout = r_line_data[{w_lane, 3'b000} +: 8];
               end else begin
                  w_nxt_state      = S_RD_CMD;
                  w_nxt_ready      = 1'b0;
                  w_nxt_ddram_rd   = 1'b1;
                  w_nxt_ddram_addr = w_word_addr;
                  w_nxt_pend_tag   = w_tag;
                  w_nxt_pend_lane  = w_lane;
               end
            end else begin
               w_nxt_state = S_IDLE;
            end
         end
         S_RD_CMD: begin
            if (!bus.ddram_busy) begin
               w_nxt_ddram_rd = 1'b0;
               w_nxt_state    = S_RD_WAIT;
            end else begin
               w_nxt_state    = S_RD_CMD;
            end
         end
         S_RD_WAIT: begin
            if (bus.ddram_dout_ready) begin
               w_nxt_line_data  = bus.ddram_dout;
               w_nxt_line_tag   = r_pend_tag;
               w_nxt_line_valid = 1'b1;
               w_nxt_dout       = bus.ddram_dout[{r_pend_lane, 3'b000} +: 8];
               w_nxt_ready      = 1'b1;
               w_nxt_state      = S_IDLE;
            end else begin
               w_nxt_state      = S_RD_WAIT;
            end
         end
         S_WR_CMD: begin
            if (!bus.ddram_busy) begin
               w_nxt_ddram_we = 1'b0;
               w_nxt_ready    = 1'b1;
               w_nxt_state    = S_IDLE;
            end else begin
               w_nxt_state    = S_WR_CMD;
            end
         end
         default: begin
            w_nxt_state    = S_IDLE;
            w_nxt_ready    = 1'b1;
            w_nxt_ddram_rd = 1'b0;
            w_nxt_ddram_we = 1'b0;
         end
      endcase

      // Losing the port invalidates the line even if a fill lands this cycle
      if (!bus.ddr3_request) begin
         w_nxt_line_valid = 1'b0;
      end else begin
         w_nxt_line_valid = w_nxt_line_valid;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Datapath, command and cache registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready      <= 1'b1;
         r_dout       <= 8'hFF;
         r_ddram_rd   <= 1'b0;
         r_ddram_we   <= 1'b0;
         r_ddram_be   <= 8'h00;
         r_ddram_din  <= 64'd0;
         r_ddram_addr <= BASE_ADDR;
         r_line_tag   <= 25'd0;
         r_line_data  <= 64'd0;
         r_line_valid <= 1'b0;
         r_pend_tag   <= 25'd0;
         r_pend_lane  <= 3'd0;
      end else begin
         r_ready      <= w_nxt_ready;
         r_dout       <= w_nxt_dout;
         r_ddram_rd   <= w_nxt_ddram_rd;
         r_ddram_we   <= w_nxt_ddram_we;
         r_ddram_be   <= w_nxt_ddram_be;
         r_ddram_din  <= w_nxt_ddram_din;
         r_ddram_addr <= w_nxt_ddram_addr;
         r_line_tag   <= w_nxt_line_tag;
         r_line_data  <= w_nxt_line_data;
         r_line_valid <= w_nxt_line_valid;
         r_pend_tag   <= w_nxt_pend_tag;
         r_pend_lane  <= w_nxt_pend_lane;
      end
   end

   assign bus.ddr3_ready     = r_ready;
   assign bus.ddr3_dout      = r_dout;
   assign bus.ddram_burstcnt = 8'd1;
   assign bus.ddram_addr     = r_ddram_addr;
   assign bus.ddram_rd       = r_ddram_rd;
   assign bus.ddram_we       = r_ddram_we;
   assign bus.ddram_din      = r_ddram_din;
   assign bus.ddram_be       = r_ddram_be;

endmodule

// File: tb/tb_ddr3_slot_bridge.sv
// Directed bench for ddr3_slot_bridge: read data expectations go through a
// scoreboard queue, command-side values are checked at each step.
module tb_ddr3_slot_bridge;

   localparam logic [28:0] BASE = 29'h0600_0000;

   logic clk = 1'b0;
   logic reset_n;

   ddr3_slot_bridge_if bus();

   ddr3_slot_bridge #(.BASE_ADDR(BASE)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_pass   = 0;
   int n_total  = 0;
   int n_fail   = 0;
   int n_rd_cyc = 0;
   int n_we_cyc = 0;
   logic [7:0] exp_q[$];

   // Count DDRAM command cycles as seen by the memory on each edge
   always @(posedge clk) begin
      if (bus.ddram_rd === 1'b1) n_rd_cyc <= n_rd_cyc + 1;
      if (bus.ddram_we === 1'b1) n_we_cyc <= n_we_cyc + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      while (bus.ddr3_ready !== 1'b1 && k < 50) begin
         step();
         k++;
      end
      chk(tag, 64'(bus.ddr3_ready), 64'd1);
   endtask

   task automatic pop_chk(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         n_total++;
         n_fail++;
         $error("FAIL %s: observed %0h expected nothing queued", tag, bus.ddr3_dout);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 64'(bus.ddr3_dout), 64'(e));
      end
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [27:0] a, input logic [7:0] d);
      bus.ddr3_addr = a;
      bus.ddr3_rd   = rd;
      bus.ddr3_wr   = wr;
      bus.ddr3_din  = d;
      step();
      bus.ddr3_rd   = 1'b0;
      bus.ddr3_wr   = 1'b0;
      bus.ddr3_addr = 28'h0;
      bus.ddr3_din  = 8'h00;
   endtask

   initial begin
      reset_n              = 1'b0;
      bus.ddr3_request     = 1'b0;
      bus.ddr3_addr        = 28'h0;
      bus.ddr3_rd          = 1'b0;
      bus.ddr3_wr          = 1'b0;
      bus.ddr3_din         = 8'h00;
      bus.ddram_busy       = 1'b0;
      bus.ddram_dout       = 64'd0;
      bus.ddram_dout_ready = 1'b0;
      step();
      step();

      chk("rst_ready",    64'(bus.ddr3_ready),     64'd1);
      chk("rst_dout",     64'(bus.ddr3_dout),      64'hFF);
      chk("rst_rd",       64'(bus.ddram_rd),       64'd0);
      chk("rst_we",       64'(bus.ddram_we),       64'd0);
      chk("rst_be",       64'(bus.ddram_be),       64'd0);
      chk("rst_din",      bus.ddram_din,           64'd0);
      chk("rst_addr",     64'(bus.ddram_addr),     64'(BASE));
      chk("rst_burstcnt", 64'(bus.ddram_burstcnt), 64'd1);

      reset_n          = 1'b1;
      bus.ddr3_request = 1'b1;
      step();

      // Read miss at byte 0x0A
      exp_q.push_back(8'h33);
      issue(1'b1, 1'b0, 28'h000_000A, 8'h00);
      chk("miss_ready_low", 64'(bus.ddr3_ready), 64'd0);
      chk("miss_ddram_rd",  64'(bus.ddram_rd),   64'd1);
      chk("miss_addr",      64'(bus.ddram_addr), 64'(BASE + 29'd1));
      step();
      step();
      step();
      bus.ddram_dout       = 64'h8877_6655_4433_2211;
      bus.ddram_dout_ready = 1'b1;
      step();
      bus.ddram_dout_ready = 1'b0;
      wait_ready("miss_ready_back");
      pop_chk("miss_dout");
      chk("miss_rd_cycles", 64'(n_rd_cyc), 64'd1);

      // Read hit at byte 0x0F
      exp_q.push_back(8'h88);
      issue(1'b1, 1'b0, 28'h000_000F, 8'h00);
      chk("hit_ready", 64'(bus.ddr3_ready), 64'd1);
      pop_chk("hit_dout");
      chk("hit_no_rd", 64'(n_rd_cyc), 64'd1);

      // Write-through at 0x0C with busy held four cycles
      bus.ddram_busy = 1'b1;
      issue(1'b0, 1'b1, 28'h000_000C, 8'h5A);
      chk("wr_we",      64'(bus.ddram_we),   64'd1);
      chk("wr_be",      64'(bus.ddram_be),   64'h10);
      chk("wr_din",     bus.ddram_din,       64'h5A5A_5A5A_5A5A_5A5A);
      chk("wr_addr",    64'(bus.ddram_addr), 64'(BASE + 29'd1));
      chk("wr_ready0",  64'(bus.ddr3_ready), 64'd0);
      step();
      step();
      step();
      step();
      bus.ddram_busy = 1'b0;
      step();
      chk("wr_we_drop",   64'(bus.ddram_we),   64'd0);
      chk("wr_we_cycles", 64'(n_we_cyc),       64'd5);
      chk("wr_ready1",    64'(bus.ddr3_ready), 64'd1);
      chk("wr_dout_kept", 64'(bus.ddr3_dout),  64'h88);
      exp_q.push_back(8'h5A);
      issue(1'b1, 1'b0, 28'h000_000C, 8'h00);
      pop_chk("wthru_hit_dout");
      chk("wthru_no_rd", 64'(n_rd_cyc), 64'd1);

      // Dropping request invalidates the line
      bus.ddr3_request = 1'b0;
      step();
      bus.ddr3_request = 1'b1;
      exp_q.push_back(8'hCC);
      issue(1'b1, 1'b0, 28'h000_000A, 8'h00);
      chk("inv_ddram_rd", 64'(bus.ddram_rd),   64'd1);
      chk("inv_ready0",   64'(bus.ddr3_ready), 64'd0);
      step();
      step();
      bus.ddram_dout       = 64'h1111_1111_11CC_1111;
      bus.ddram_dout_ready = 1'b1;
      step();
      bus.ddram_dout_ready = 1'b0;
      wait_ready("inv_ready_back");
      pop_chk("inv_dout");
      chk("inv_rd_cycles", 64'(n_rd_cyc), 64'd2);

      // Simultaneous rd and wr: write wins
      issue(1'b1, 1'b1, 28'h000_0010, 8'hC3);
      chk("rw_we",   64'(bus.ddram_we),   64'd1);
      chk("rw_rd",   64'(bus.ddram_rd),   64'd0);
      chk("rw_be",   64'(bus.ddram_be),   64'h01);
      chk("rw_addr", 64'(bus.ddram_addr), 64'(BASE + 29'd2));
      chk("rw_din",  bus.ddram_din,       64'hC3C3_C3C3_C3C3_C3C3);
      step();
      chk("rw_ready",    64'(bus.ddr3_ready), 64'd1);
      chk("rw_no_rd",    64'(n_rd_cyc),       64'd2);
      chk("rw_dout_kept", 64'(bus.ddr3_dout), 64'hCC);

      // Top of the byte range: highest word and lane 7
      issue(1'b0, 1'b1, 28'hFFF_FFFF, 8'h7E);
      chk("top_addr", 64'(bus.ddram_addr), 64'(29'h07FF_FFFF));
      chk("top_be",   64'(bus.ddram_be),   64'h80);
      step();

      // Reset in RD_WAIT, then a late dout_ready that must be discarded
      issue(1'b1, 1'b0, 28'h000_0018, 8'h00);
      step();
      reset_n = 1'b0;
      #1;
      chk("rstmid_ready", 64'(bus.ddr3_ready), 64'd1);
      chk("rstmid_rd",    64'(bus.ddram_rd),   64'd0);
      chk("rstmid_dout",  64'(bus.ddr3_dout),  64'hFF);
      step();
      reset_n = 1'b1;
      step();
      bus.ddram_dout       = 64'hDEAD_BEEF_DEAD_BEEF;
      bus.ddram_dout_ready = 1'b1;
      step();
      bus.ddram_dout_ready = 1'b0;
      chk("late_ready", 64'(bus.ddr3_ready), 64'd1);
      chk("late_dout",  64'(bus.ddr3_dout),  64'hFF);

      // Line was cleared: previously cached word must miss
      exp_q.push_back(8'h77);
      issue(1'b1, 1'b0, 28'h000_000A, 8'h00);
      chk("postrst_miss", 64'(bus.ddram_rd), 64'd1);
      step();
      bus.ddram_dout       = 64'h0000_0000_0077_0000;
      bus.ddram_dout_ready = 1'b1;
      step();
      bus.ddram_dout_ready = 1'b0;
      wait_ready("postrst_ready");
      pop_chk("postrst_dout");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
